// File: rtl/cordic_roundtrip_check_pkg.sv
// Shared types and helpers for the CORDIC round-trip checker.
// Holds the FSM state type, counter width and the wrap-aware distance.
package cordic_chk_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DRAIN,
        ST_DONE
    } state_e;

    localparam int CNT_W = 16;
    localparam int FN_W  = 32;

    // |b - a| on a w-bit circle; the half-circle point maps to 2^(w-1)
    function automatic logic [FN_W-1:0] abs_wrap_diff(
        input logic [FN_W-1:0] a,
        input logic [FN_W-1:0] b,
        input int unsigned     w
    );
        logic [FN_W-1:0] mask;
        logic [FN_W-1:0] d;
        mask = (w >= FN_W) ? '1 : ((FN_W'(1) << w) - FN_W'(1));
        d    = (b - a) & mask;
        if (d > (mask >> 1)) begin
            abs_wrap_diff = (~d + FN_W'(1)) & mask;
        end else begin
            abs_wrap_diff = d;
        end
    endfunction

endpackage

// File: rtl/cordic_roundtrip_check_if.sv
// Stimulus/response bundle between the CORDIC pipeline and the checker.
// master drives the strobes and data, slave is the checker side.
interface cordic_chk_if #(
    parameter int WIDTH = 18
) ();
    logic             start;
    logic             in_valid;
    logic [WIDTH:0]   phase_in;
    logic             ret_valid;
    logic [WIDTH:0]   phase_ret;
    logic [WIDTH-1:0] mag_exp;
    logic [WIDTH-1:0] mag_ret;

    modport master (
        output start, in_valid, phase_in,
        output ret_valid, phase_ret,
        output mag_exp, mag_ret
    );

    modport slave (
        input start, in_valid, phase_in,
        input ret_valid, phase_ret,
        input mag_exp, mag_ret
    );
endinterface

// File: rtl/cordic_roundtrip_check_fifo.sv
// Single-clock FIFO holding phases applied but not yet returned.
// Pointers carry an extra wrap bit so full and empty are distinct.
module cordic_chk_fifo #(
    parameter int DEPTH = 64,
    parameter int DW    = 19
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clr_i,
    input  logic          wr_i,
    input  logic          rd_i,
    input  logic [DW-1:0] din_i,
    output logic [DW-1:0] dout_o,
    output logic          full_o,
    output logic          empty_o
);
    localparam int AW = $clog2(DEPTH);

    logic [DW-1:0] mem_q [DEPTH];
    logic [AW:0]   wptr_q, wptr_d;
    logic [AW:0]   rptr_q, rptr_d;

    // next pointer values; clear wins over any access
    always_comb begin
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        if (clr_i) begin
            wptr_d = '0;
            rptr_d = '0;
        end else begin
            if (wr_i) wptr_d = wptr_q + (AW+1)'(1);
            if (rd_i) rptr_d = rptr_q + (AW+1)'(1);
        end
    end

    // pointer registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
        end
    end

    // storage array, written at the tail
    always_ff @(posedge clk) begin
        if (wr_i && !clr_i) mem_q[wptr_q[AW-1:0]] <= din_i;
    end

    assign dout_o  = mem_q[rptr_q[AW-1:0]];
    assign empty_o = (wptr_q == rptr_q);
    assign full_o  = (wptr_q[AW] != rptr_q[AW]) &&
                     (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
endmodule

// File: rtl/cordic_roundtrip_check.sv
// Round-trip phase checker: pairs applied and returned phases, keeps stats.
// Optional magnitude check enabled by defining CORDIC_MAG_CHECK_EN.
module cordic_roundtrip_check
    import cordic_chk_pkg::*;
#(
    parameter int WIDTH  = 18,
    parameter int TOL    = 8,
    parameter int NCHECK = 4000,
    parameter int DEPTH  = 64
) (
    input  logic             clk,
    input  logic             rst_n,
    cordic_chk_if.slave      chk,
    output logic             busy_o,
    output logic             done_o,
    output logic             pass_o,
    output logic [CNT_W-1:0] fail_cnt_o,
    output logic [WIDTH:0]   max_err_o,
    output logic [CNT_W-1:0] n_checked_o,
`ifdef CORDIC_MAG_CHECK_EN
    output logic [WIDTH:0]   mag_max_err_o,
`endif
    output logic             ovf_o,
    output logic             unf_o
);
    localparam int PW = WIDTH + 1;
`ifdef CORDIC_MAG_CHECK_EN
    localparam int DW = PW + WIDTH;
`else
    localparam int DW = PW;
`endif
    localparam logic [WIDTH:0]   TOL_V     = PW'(TOL);
    localparam logic [CNT_W-1:0] ACC_LAST  = CNT_W'(NCHECK - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    state_e           state_q;
    logic             busy_q, done_q, pass_q;
    logic             ovf_q, unf_q;
    logic [CNT_W-1:0] acc_q, fail_q, nchk_q;
    logic [WIDTH:0]   max_q;
    logic             cmp_v_q;
    logic [WIDTH:0]   cmp_exp_q, cmp_ret_q;

    logic             full, empty;
    logic [DW-1:0]    wdata, head;
    logic [WIDTH:0]   head_ph;
    logic             active;
    logic             push_req, pop_req, push_ok, pop_ok;
    logic [WIDTH:0]   ph_err;
    logic             bad;

    assign active   = (state_q == ST_RUN) || (state_q == ST_DRAIN);
    assign push_req = (state_q == ST_RUN) && chk.in_valid && !chk.start;
    assign pop_req  = active && chk.ret_valid && !chk.start;
    assign pop_ok   = pop_req && !empty;
    assign push_ok  = push_req && (!full || pop_ok);

    assign ph_err = PW'(abs_wrap_diff(FN_W'(cmp_exp_q),
                                      FN_W'(cmp_ret_q), PW));

`ifdef CORDIC_MAG_CHECK_EN
    logic [WIDTH-1:0] cmp_mexp_q, cmp_mret_q;
    logic [WIDTH:0]   mag_max_q;
    logic [WIDTH:0]   mag_err;

    assign wdata   = {chk.phase_in, chk.mag_exp};
    assign head_ph = head[DW-1 -: PW];
    assign mag_err = PW'(abs_wrap_diff(FN_W'(cmp_mexp_q),
                                       FN_W'(cmp_mret_q), PW));
    assign bad     = (ph_err > TOL_V) || (mag_err > TOL_V);
    assign mag_max_err_o = mag_max_q;

    // magnitude half of the comparison stage and its running maximum
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cmp_mexp_q <= '0;
            cmp_mret_q <= '0;
            mag_max_q  <= '0;
        end else if (chk.start) begin
            mag_max_q  <= '0;
        end else begin
            if (pop_ok) begin
                cmp_mexp_q <= head[WIDTH-1:0];
                cmp_mret_q <= chk.mag_ret;
            end
            if (cmp_v_q && mag_err > mag_max_q) mag_max_q <= mag_err;
        end
    end
`else
    logic unused_mag;

    assign unused_mag = ^{chk.mag_exp, chk.mag_ret};
    assign wdata      = chk.phase_in;
    assign head_ph    = head;
    assign bad        = (ph_err > TOL_V);
`endif

    cordic_chk_fifo #(
        .DEPTH (DEPTH),
        .DW    (DW)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr_i   (chk.start),
        .wr_i    (push_ok),
        .rd_i    (pop_ok),
        .din_i   (wdata),
        .dout_o  (head),
        .full_o  (full),
        .empty_o (empty)
    );

    // run control, comparison stage and statistics
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            pass_q    <= 1'b0;
            ovf_q     <= 1'b0;
            unf_q     <= 1'b0;
            acc_q     <= '0;
            fail_q    <= '0;
            nchk_q    <= '0;
            max_q     <= '0;
            cmp_v_q   <= 1'b0;
            cmp_exp_q <= '0;
            cmp_ret_q <= '0;
        end else if (chk.start) begin
            state_q   <= ST_RUN;
            busy_q    <= 1'b1;
            done_q    <= 1'b0;
            pass_q    <= 1'b0;
            ovf_q     <= 1'b0;
            unf_q     <= 1'b0;
            acc_q     <= '0;
            fail_q    <= '0;
            nchk_q    <= '0;
            max_q     <= '0;
            cmp_v_q   <= 1'b0;
        end else begin
            cmp_v_q <= pop_ok;
            if (pop_ok) begin
                cmp_exp_q <= head_ph;
                cmp_ret_q <= chk.phase_ret;
            end
            if (cmp_v_q) begin
                nchk_q <= nchk_q + CNT_ONE;
                if (bad && fail_q != '1) fail_q <= fail_q + CNT_ONE;
                if (ph_err > max_q) max_q <= ph_err;
            end
            if (push_req && full && !pop_ok) ovf_q <= 1'b1;
            if (pop_req && empty) unf_q <= 1'b1;
            if (push_req) acc_q <= acc_q + CNT_ONE;
            unique case (state_q)
                ST_RUN: begin
                    if (push_req && acc_q == ACC_LAST) state_q <= ST_DRAIN;
                end
                ST_DRAIN: begin
                    if (empty && !cmp_v_q) begin
                        state_q <= ST_DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        pass_q  <= (fail_q == '0) && !ovf_q &&
                                   !(unf_q || (pop_req && empty));
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign busy_o      = busy_q;
    assign done_o      = done_q;
    assign pass_o      = pass_q;
    assign fail_cnt_o  = fail_q;
    assign max_err_o   = max_q;
    assign n_checked_o = nchk_q;
    assign ovf_o       = ovf_q;
    assign unf_o       = unf_q;
endmodule

// File: doc/cordic_roundtrip_check.md
# cordic_roundtrip_check

Synthesizable self-checker for the CORDIC pipeline in round-trip configuration: a rotate-mode pass followed by a vectoring-mode pass must return the applied phase. The block sits after the vectoring CORDIC. It queues each phase applied at the forward input, pairs it with the phase returned by the vectoring pass, and accumulates pass/fail statistics. This lets accuracy be measured on hardware without a post-processing trace.

## Interface
- width, 18, CORDIC data width; phase words are width+1 bits
- tol, 8, maximum allowed absolute phase error, in phase LSBs
- ncheck, 4000, number of samples accepted per run
- depth, 64, FIFO depth; power of two; at least 2*nstg+8
- clk  in  1  sole clock, rising edge
- rst_n  in  1  reset, asynchronous, active-low
- start  in  1  one-cycle pulse; clears statistics and begins a run
- in_valid  in  1  strobe: phase_in was applied to the forward CORDIC this cycle
- phase_in  in  width+1  phase applied (unsigned, full-circle wrap)
- ret_valid  in  1  strobe: vectoring CORDIC output is valid this cycle
- phase_ret  in  width+1  returned phase
- mag_exp  in  width  expected returned magnitude, sampled with in_valid (used only with the macro)
- mag_ret  in  width  returned magnitude (used only with the macro)
- busy  out  1  high in RUN or DRAIN
- done  out  1  high in DONE
- pass  out  1  done & fail_cnt==0 & !ovf & !unf
- fail_cnt  out  16  samples whose error exceeds tol; saturates at 0xFFFF
- max_err  out  width+1  largest absolute phase error seen
- n_checked  out  16  comparisons performed
- ovf, unf  out  1 each  sticky FIFO overflow / underflow flags

## Operation
- FSM states:
  - IDLE: no pushes, no pops.
  - RUN: push on in_valid, pop on ret_valid.
  - DRAIN: pops only; in_valid is ignored.
  - DONE: inputs are ignored.
- Transitions:
  - start in any state: clear FIFO, all counters and flags; go to RUN.
  - RUN to DRAIN: when the accepted-push count reaches ncheck.
  - DRAIN to DONE: when the FIFO is empty and no comparison is pending.
- Push: {phase_in, mag_exp} enters the FIFO.
- Pop: the FIFO head is compared against phase_ret.
- Phase error: err = phase_ret - head, computed modulo 2^(width+1) and interpreted as signed; abs_err = |err|.
- The most-negative err value maps to abs_err = 2^width; no overflow occurs.
- If abs_err > tol: fail_cnt increments. max_err = max(max_err, abs_err). n_checked increments on every comparison.
- Full FIFO with push and no pop: sample dropped, ovf set, accepted count still increments.
- Full FIFO with push and pop in the same cycle: both occur.
- Empty FIFO with pop: no comparison, unf set.
- Empty FIFO with push and pop in the same cycle: no bypass; treated as underflow, push is kept.
- Reset values: all outputs 0; state IDLE; FIFO empty.

## Timing
- Comparison is registered. With ret_valid at edge t, fail_cnt, max_err and n_checked reflect that sample after edge t+1.
- FIFO read is combinational from the head. One push and one pop are allowed per cycle.
- done rises one cycle after the last comparison is registered.
- start sampled with in_valid high: the clear takes priority and that sample is not pushed.
- start sampled with ret_valid high: the clear takes priority and that sample is not compared.
- rst_n asserted mid-run: immediate return to the reset state. No partial statistics are kept.

## Configuration
- CORDIC_MAG_CHECK_EN defined:
  - The FIFO also stores mag_exp.
  - A sample fails if abs_err > tol, or if |mag_ret - mag_exp| > tol, where mag_ret - mag_exp is a signed width+1 difference.
  - Output mag_max_err [width:0] holds the largest magnitude error; it resets to 0.
- CORDIC_MAG_CHECK_EN undefined:
  - mag_exp and mag_ret are ignored and the FIFO is width+1 bits wide.
  - mag_max_err is absent.

## Structure
- Package cordic_chk_pkg holds:
  - the state enum (ST_IDLE, ST_RUN, ST_DRAIN, ST_DONE);
  - the counter width constant CNT_W = 16;
  - a function abs_wrap_diff(a, b) returning the modular absolute difference.
- One sub-module: cordic_chk_fifo, a synchronous single-clock FIFO with parameters depth and data width.
  - Outputs: full, empty, head data.
  - The wrap pointers carry one extra bit to distinguish full from empty.
- The top level holds the FSM, the comparator and the statistics registers.

## Test plan
- Ideal loopback: ncheck=100, phase_ret = phase_in delayed 40 cycles → done=1, pass=1, fail_cnt=0, max_err=0, n_checked=100.
- Offset: phase_ret = phase_in+9 with tol=8 → fail_cnt=100, max_err=9, pass=0. Offset +8 → pass=1, max_err=8.
- Wrap-around: phase_in=2^19-2 (width=18), phase_ret=1 → abs_err=3, no fail, max_err=3.
- Overflow: 70 in_valid with no ret_valid, depth=64 → ovf=1 after the 65th push; the FIFO holds the first 64 samples; pass=0 at DONE.
- Underflow: ret_valid while empty in RUN → unf=1, n_checked unchanged.
- Reset mid-run: rst_n low for 1 cycle after 50 comparisons → all outputs 0, state IDLE. A following start runs cleanly to pass=1.
